// File: rtl/int_dispatch.sv
// int_dispatch
//   Sits downstream of the interrupt controller. Every id the controller
//   announces with `available` is pushed into a small FIFO and offered to the
//   CPU as an interrupt request with a handler vector. One interrupt is in
//   service at a time: request -> ack -> service -> eoi.
//
// Handshakes (single place where they are described):
//   controller side: `available` is a one-cycle strobe qualifying `dev_id`.
//     `ic_enable` is the controller's enable; it drops for one cycle after
//     every sampled `available` (re-arm) and stays low while the FIFO is full.
//   CPU side: `irq` is held with a stable `vector` until either `ack` is
//     sampled (the id is consumed and the block enters service) or `int_en`
//     is withdrawn (the id stays queued and is re-requested later). `ack` wins
//     over a simultaneous withdrawal. `eoi` ends service. `ack` outside a
//     request and `eoi` outside service are ignored.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   dev_id         id from the controller, qualified by available
//   available      one-cycle capture strobe
//   ic_enable      enable back to the controller (registered)
//   int_en         CPU global interrupt enable
//   irq, vector    interrupt request and handler address (registered)
//   ack, eoi       CPU accept / end-of-interrupt pulses
//   busy           an interrupt is in service
//   queue_count    number of queued ids
//   overflow       sticky: an id was dropped because the queue was full

module int_dispatch #(
  parameter int                    DEV_ID_SIZE = 8,
  parameter int                    ADDR_SIZE   = 16,
  parameter logic [ADDR_SIZE-1:0]  VEC_BASE    = 16'h0100,
  parameter int                    VEC_SHIFT   = 1,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DEV_ID_SIZE-1:0]        dev_id,
  input  logic                          available,
  output logic                          ic_enable,
  input  logic                          int_en,
  output logic                          irq,
  output logic [ADDR_SIZE-1:0]          vector,
  input  logic                          ack,
  input  logic                          eoi,
  output logic                          busy,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic                          overflow
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t state, state_next;

  // pending-id FIFO
  logic [DEV_ID_SIZE-1:0] mem [QUEUE_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_next;
  logic                   full, empty;
  logic                   push, pop, drop;
  logic [DEV_ID_SIZE-1:0] head;
  logic [ADDR_SIZE-1:0]   head_vector;

  logic                   irq_next, busy_next;
  logic [ADDR_SIZE-1:0]   vector_next;
  logic                   ic_enable_next;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // The head is only consumed when the CPU accepts the request.
  assign pop  = (state == S_REQUEST) && ack;
  // A push into a full queue is legal when the same edge pops.
  assign push = available && (!full || pop);
  assign drop = available && full && !pop;

  // Zero-extend the id, scale by the table stride, wrap to ADDR_SIZE.
  assign head_vector = VEC_BASE + (ADDR_SIZE'(head) << VEC_SHIFT);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Re-arm pulse after any sampled strobe; hold low while the queue is full.
  assign ic_enable_next = !available && (count_next != DEPTH_C);

  always_comb begin
    state_next  = state;
    irq_next    = irq;
    busy_next   = busy;
    vector_next = vector;
    case (state)
      S_IDLE: begin
        if (!empty && int_en) begin
          irq_next    = 1'b1;
          vector_next = head_vector;
          state_next  = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (ack) begin
          irq_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = S_SERVICE;
        end else if (!int_en) begin
          irq_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: begin
        irq_next   = 1'b0;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      irq       <= 1'b0;
      busy      <= 1'b0;
      vector    <= '0;
      ic_enable <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_next;
      irq       <= irq_next;
      busy      <= busy_next;
      vector    <= vector_next;
      ic_enable <= ic_enable_next;
      count     <= count_next;
      if (drop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dev_id;
  end

  assign queue_count = count;

endmodule

// File: tb/tb_int_dispatch.sv
// tb_int_dispatch
//   Bench for int_dispatch. Inputs change 2 time units after each rising edge.
//   A reference model updates on the rising edge from the protocol rules
//   (queue of ids, request/service phase); a negedge monitor compares every
//   output against it, and on each accepted request pops the expected vector
//   from a scoreboard queue filled at capture time (FIFO service order).

module tb_int_dispatch;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int VB    = 'h0100;
  localparam int VS    = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dev_id;
  logic          available;
  logic          ic_enable;
  logic          int_en;
  logic          irq;
  logic [AW-1:0] vector;
  logic          ack;
  logic          eoi;
  logic          busy;
  logic [2:0]    queue_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  int_dispatch #(
    .DEV_ID_SIZE (DW),
    .ADDR_SIZE   (AW),
    .VEC_BASE    (16'h0100),
    .VEC_SHIFT   (VS),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_id      (dev_id),
    .available   (available),
    .ic_enable   (ic_enable),
    .int_en      (int_en),
    .irq         (irq),
    .vector      (vector),
    .ack         (ack),
    .eoi         (eoi),
    .busy        (busy),
    .queue_count (queue_count),
    .overflow    (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] vec_of(input int id);
    return AW'(VB + id * (1 << VS));
  endfunction

  // ---------------- reference model ----------------
  int            m_q[$];
  logic [AW-1:0] exp_q[$];
  int            m_phase;   // 0 idle, 1 requesting, 2 in service
  bit            m_irq, m_busy, m_ovf, m_ic, m_pop;
  logic [AW-1:0] m_vec;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_phase = 0;
      m_irq   = 0;
      m_busy  = 0;
      m_ovf   = 0;
      m_ic    = 0;
      m_vec   = '0;
    end else begin
      m_pop = (m_phase == 1) && ack;
      case (m_phase)
        0: if (m_q.size() > 0 && int_en) begin
             m_irq   = 1;
             m_vec   = vec_of(m_q[0]);
             m_phase = 1;
           end
        1: if (ack) begin
             m_irq   = 0;
             m_busy  = 1;
             m_phase = 2;
           end else if (!int_en) begin
             m_irq   = 0;
             m_phase = 0;
           end
        default: if (eoi) begin
             m_busy  = 0;
             m_phase = 0;
           end
      endcase
      if (m_pop) void'(m_q.pop_front());
      if (available) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(int'(dev_id));
          exp_q.push_back(vec_of(int'(dev_id)));
        end else begin
          m_ovf = 1;
        end
      end
      m_ic = !available && (m_q.size() != DEPTH);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    chk("irq", irq, m_irq);
    chk("busy", busy, m_busy);
    chk("ic_enable", ic_enable, m_ic);
    chk("queue_count", queue_count, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("vector", vector, m_vec);
    if (!rst && irq && ack) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        chk("served_vector", vector, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    available = 0;
    dev_id    = '0;
    ack       = 0;
    eoi       = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    int_en = 0;
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic cap(input int id);
    available = 1;
    dev_id    = DW'(id);
    cyc();
    available = 0;
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!irq && n < 20) begin
      cyc();
      n++;
    end
    if (!irq) chk("irq_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input logic [AW-1:0] exp_vec);
    wait_irq();
    chk("serve_vector", vector, exp_vec);
    ack = 1;
    cyc();
    ack = 0;
    chk("serve_irq_low", irq, 0);
    chk("serve_busy", busy, 1);
    eoi = 1;
    cyc();
    eoi = 0;
    chk("serve_busy_end", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    int_en = 0;
    clear_inputs();
    cyc();
    cyc();
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vector", vector, 0);
    chk("rst_ic_enable", ic_enable, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", queue_count, 0);
    rst = 0;
    cyc();
    chk("ic_enable_after_rst", ic_enable, 1);

    // single request
    int_en = 1;
    cap(8'h05);
    chk("t1_count", queue_count, 1);
    chk("t1_rearm", ic_enable, 0);
    chk("t1_irq_not_yet", irq, 0);
    cyc();
    chk("t1_irq", irq, 1);
    chk("t1_vector", vector, 16'h010A);
    chk("t1_rearm_end", ic_enable, 1);
    ack = 1;
    cyc();
    ack = 0;
    chk("t1_ack_irq", irq, 0);
    chk("t1_ack_busy", busy, 1);
    chk("t1_ack_count", queue_count, 0);
    eoi = 1;
    cyc();
    eoi = 0;
    chk("t1_eoi_busy", busy, 0);

    // ordering with captures during service
    do_reset();
    int_en = 1;
    cap(8'h05);
    wait_irq();
    ack = 1;
    cyc();
    ack = 0;
    available = 1;
    dev_id = 8'd3; cyc();
    dev_id = 8'd7; cyc();
    dev_id = 8'd1; cyc();
    available = 0;
    chk("t2_count", queue_count, 3);
    chk("t2_rearm_b2b", ic_enable, 0);
    chk("t2_no_nesting", irq, 0);
    eoi = 1;
    cyc();
    eoi = 0;
    serve(16'h0106);
    serve(16'h010E);
    serve(16'h0102);

    // full queue and overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      available = 1;
      dev_id = DW'(10 + i);
      cyc();
      if (i == 3) begin
        chk("t3_full_count", queue_count, 4);
        chk("t3_full_ovf", overflow, 0);
      end
    end
    available = 0;
    chk("t3_ovf", overflow, 1);
    chk("t3_count_after_drop", queue_count, 4);
    cyc();
    chk("t3_ic_held_low", ic_enable, 0);
    int_en = 1;
    wait_irq();
    chk("t3_vector", vector, 16'h0114);
    ack = 1;
    cyc();
    ack = 0;
    chk("t3_count_after_ack", queue_count, 3);
    chk("t3_ic_back", ic_enable, 1);
    eoi = 1;
    cyc();
    eoi = 0;
    serve(16'h0116);
    serve(16'h0118);
    serve(16'h011A);
    chk("t3_ovf_sticky", overflow, 1);

    // simultaneous push and pop at full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      available = 1;
      dev_id = DW'(i);
      cyc();
    end
    available = 0;
    int_en = 1;
    wait_irq();
    chk("t4_count_full", queue_count, 4);
    available = 1;
    dev_id = 8'd9;
    ack = 1;
    cyc();
    available = 0;
    ack = 0;
    chk("t4_count_same", queue_count, 4);
    chk("t4_no_ovf", overflow, 0);
    chk("t4_busy", busy, 1);
    eoi = 1;
    cyc();
    eoi = 0;
    serve(16'h0104);
    serve(16'h0106);
    serve(16'h0108);
    serve(16'h0112);

    // enable withdrawal
    do_reset();
    int_en = 1;
    cap(8'd2);
    wait_irq();
    int_en = 0;
    cyc();
    chk("t5_irq_dropped", irq, 0);
    chk("t5_count_kept", queue_count, 1);
    int_en = 1;
    cyc();
    chk("t5_irq_again", irq, 1);
    chk("t5_vector", vector, 16'h0104);
    ack = 1;
    cyc();
    ack = 0;
    eoi = 1;
    cyc();
    eoi = 0;

    // async reset mid-service
    do_reset();
    for (int i = 0; i < 5; i++) begin
      available = 1;
      dev_id = DW'(20 + i);
      cyc();
    end
    available = 0;
    int_en = 1;
    wait_irq();
    ack = 1;
    cyc();
    ack = 0;
    chk("t6_busy_before", busy, 1);
    #1;
    rst = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_irq", irq, 0);
    chk("t6_ic_enable", ic_enable, 0);
    chk("t6_count", queue_count, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_vector", vector, 0);
    cyc();
    rst = 0;
    cyc();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      available = ($urandom_range(0, 2) == 0);
      dev_id    = DW'($urandom_range(0, 255));
      int_en    = ($urandom_range(0, 7) != 0);
      ack       = ($urandom_range(0, 1) == 1);
      eoi       = ($urandom_range(0, 2) == 0);
      cyc();
    end
    clear_inputs();
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_dispatch.md
# int_dispatch

Downstream companion of the interrupt controller: captures each `dev_id` the controller announces with its `available` pulse, queues it, and presents it to the CPU as an interrupt request with a computed handler vector. It also drives the controller's `enable` input, dropping it for one cycle after every capture so the controller re-arms, and holding it low while the queue is full. It runs a request / acknowledge / end-of-interrupt sequence with the CPU, with one interrupt in service at a time.

## Interface
- `DEV_ID_SIZE`, 8, width of device id; must match the controller.
- `ADDR_SIZE`, 16, width of the vector address.
- `VEC_BASE`, 16'h0100, base address of the handler vector table.
- `VEC_SHIFT`, 1, log2 of the vector table entry stride.
- `QUEUE_DEPTH`, 4, pending-id queue entries; power of two, ≥2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dev_id`  in  DEV_ID_SIZE  id from the controller; valid when `available`=1.
- `available`  in  1  one-cycle capture strobe from the controller.
- `ic_enable`  out  1  drives the controller's `enable`.
- `int_en`  in  1  CPU global interrupt enable.
- `irq`  out  1  interrupt request to the CPU.
- `vector`  out  ADDR_SIZE  handler address; valid while `irq`=1.
- `ack`  in  1  CPU accepts the request (one-cycle pulse).
- `eoi`  in  1  CPU end of interrupt (one-cycle pulse).
- `busy`  out  1  an interrupt is in service.
- `queue_count`  out  log2(QUEUE_DEPTH)+1  number of queued ids.
- `overflow`  out  1  sticky: an id was dropped.

## Operation
- Reset (async, immediate): queue empty, state IDLE, `irq`=0, `busy`=0, `vector`=0, `ic_enable`=0, `overflow`=0, `queue_count`=0.
- Capture
  - On a rising edge with `available`=1, push `dev_id` if `queue_count`<QUEUE_DEPTH.
  - Otherwise drop it and set `overflow`. Only reset clears `overflow`.
- Queue behaviour
  - FIFO; pointers wrap modulo QUEUE_DEPTH.
  - Simultaneous push and pop: `queue_count` is unchanged and both operations take effect. This is legal when full, because the pop frees the slot.
- `ic_enable` (registered)
  - 0 in the cycle after any edge that sampled `available`=1 (re-arm pulse).
  - 0 while `queue_count`=QUEUE_DEPTH.
  - 1 otherwise.
- State machine
  - IDLE: if queue non-empty and `int_en`=1, register `irq`=1 and `vector` = VEC_BASE + (head << VEC_SHIFT), then go to REQUEST. The head is not popped yet.
  - REQUEST, `ack`=1: pop the head, `irq`→0, `busy`→1, go to SERVICE. `ack` has priority over `int_en` in the same cycle.
  - REQUEST, `int_en`=0 (no `ack`): `irq`→0, go to IDLE. Nothing is popped; the same id is re-requested later.
  - SERVICE: `busy`=1. On `eoi`, `busy`→0 and go to IDLE. New captures keep queuing; there is no nesting.
- Ignored inputs: `ack` outside REQUEST, and `eoi` outside SERVICE.
- Vector arithmetic: `dev_id` is zero-extended before the shift, and the sum is truncated to ADDR_SIZE (wraps).
- `vector` holds its last value after `irq` falls.

## Timing
- `available` sampled at edge E:
  - id is queued and `queue_count` increments after E;
  - `ic_enable`=0 during the following cycle;
  - `irq`=1 after E+1 at the earliest (state IDLE, `int_en`=1).
- `ack` sampled at edge A: after A, `irq`=0, `busy`=1, `queue_count` decrements.
- `eoi` sampled at edge B: after B, `busy`=0. The next `irq` is asserted after B+1 if the queue is non-empty.
- Back-to-back `available` on consecutive edges: both are captured if space allows. `ic_enable` stays 0 through the cycle after the last one.
- `rst` asserted mid-REQUEST or mid-SERVICE: all outputs go to their reset values immediately and queue contents are lost.

## Test plan
- Single request (`int_en`=1, defaults): `available` with `dev_id`=8'h05 → `irq`=1 one cycle after capture, `vector`=16'h010A, `ic_enable` low for exactly one cycle. Then `ack` → `irq`=0, `busy`=1, `queue_count`=0. Then `eoi` → `busy`=0.
- Ordering (`int_en`=1): capture ids 3, 7, 1 while the first is in service → after each `ack`/`eoi` cycle, vectors 16'h0106, 16'h010E, 16'h0102 appear in that order.
- Full queue / overflow (`int_en`=0): 4 captures → `queue_count`=4, `ic_enable` held 0. A fifth `available` → dropped, `overflow`=1. Then `int_en`=1 and one `ack` → `queue_count`=3, `ic_enable` returns to 1.
- Simultaneous push and pop at full: `queue_count`=4 in REQUEST; `available` (id 9) and `ack` on the same edge → `queue_count` stays 4, `overflow`=0, and id 9 is served last.
- Enable withdrawal: in REQUEST with id 2, drop `int_en` → `irq`=0 and `queue_count` unchanged. Re-raise `int_en` → `irq`=1 with `vector`=16'h0104.
- Async reset mid-SERVICE: assert `rst` between clock edges → `busy`, `irq`, `ic_enable`, `queue_count` and `overflow` are 0 before the next edge.
